gb_capture_ctrl: RTL and testbench

//   Sequences Game Boy LCD capture into a double-banked 2-bit framebuffer.

---
 rtl/gb_capture_ctrl_if.sv | 34 +++
 rtl/gb_capture_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_gb_capture_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_capture_ctrl_if.sv
// Bundle between the LCD capture sequencer and its surroundings: raw LCD pins,
// the VGA vsync, and the framebuffer write port.
interface gb_capture_ctrl_if #(
  parameter int ADDR_W = 15
) ();
  // Write port is a plain strobe: wr_addr/wr_data are meaningful only in a
  // cycle where wr_en is 1, and the framebuffer must take every strobe.
  // There is no ready; the sequencer never stalls.
  logic [1:0]      idata;
  logic            iclk;
  logic            ihsync;
  logic            ivsync;
  logic            ovsync;
  logic [ADDR_W:0] wr_addr;
  logic [1:0]      wr_data;
  logic            wr_en;
  logic            rd_bank;
  logic            capturing;
  logic            frame_ok;
  logic            frame_err;
  logic [7:0]      err_count;

  modport master (
    input  idata, iclk, ihsync, ivsync, ovsync,
    output wr_addr, wr_data, wr_en, rd_bank, capturing, frame_ok, frame_err,
           err_count
  );

  modport slave (
    output idata, iclk, ihsync, ivsync, ovsync,
    input  wr_addr, wr_data, wr_en, rd_bank, capturing, frame_ok, frame_err,
           err_count
  );
endinterface

// File: rtl/gb_capture_ctrl.sv
// Game Boy LCD capture sequencer: synchronises the LCD pins, validates each
// frame's geometry, writes pixels into the back bank and swaps banks on VGA vsync.
module gb_capture_ctrl #(
  parameter int H_PIX       = 160,
  parameter int V_LINES     = 144,
  parameter int ADDR_W      = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  gb_capture_ctrl_if.master bus,
  output logic [1:0]        dbg_state_o,
  output logic              dbg_pending_o,
  output logic              dbg_wr_bank_o
);

  localparam int XW = $clog2(H_PIX + 1);
  localparam int YW = $clog2(V_LINES + 1);

  localparam logic [1:0] ST_WAIT    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [XW-1:0] X_END  = XW'(H_PIX);
  localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

  // ---------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0]      iclk_s_q;
  logic [SYNC_STAGES-1:0]      hs_s_q;
  logic [SYNC_STAGES-1:0]      vs_s_q;
  logic [SYNC_STAGES-1:0][1:0] data_s_q;
  logic                        iclk_p_q;
  logic                        hs_p_q;
  logic                        vs_p_q;
  logic                        ev_iclk_q;
  logic                        ev_hs_q;
  logic                        ev_vs_q;
  logic [1:0]                  ev_data_q;
  logic                        ovs_q;
  logic                        ovs_rise;

  // Data goes through the same depth as iclk so the sample stays aligned
  // with the rising edge that qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iclk_s_q  <= '0;
      hs_s_q    <= '0;
      vs_s_q    <= '0;
      data_s_q  <= '0;
      iclk_p_q  <= 1'b0;
      hs_p_q    <= 1'b0;
      vs_p_q    <= 1'b0;
      ev_iclk_q <= 1'b0;
      ev_hs_q   <= 1'b0;
      ev_vs_q   <= 1'b0;
      ev_data_q <= 2'd0;
      ovs_q     <= 1'b0;
    end else begin
      iclk_s_q  <= {iclk_s_q[SYNC_STAGES-2:0], bus.iclk};
      hs_s_q    <= {hs_s_q[SYNC_STAGES-2:0], bus.ihsync};
      vs_s_q    <= {vs_s_q[SYNC_STAGES-2:0], bus.ivsync};
      data_s_q  <= {data_s_q[SYNC_STAGES-2:0], bus.idata};
      iclk_p_q  <= iclk_s_q[SYNC_STAGES-1];
      hs_p_q    <= hs_s_q[SYNC_STAGES-1];
      vs_p_q    <= vs_s_q[SYNC_STAGES-1];
      ev_iclk_q <= iclk_s_q[SYNC_STAGES-1] & ~iclk_p_q;
      ev_hs_q   <= hs_s_q[SYNC_STAGES-1] & ~hs_p_q;
      ev_vs_q   <= vs_s_q[SYNC_STAGES-1] & ~vs_p_q;
      ev_data_q <= data_s_q[SYNC_STAGES-1];
      ovs_q     <= bus.ovsync;
    end
  end

  assign ovs_rise = bus.ovsync & ~ovs_q;

  // ---------------------------------------------------------------------
  // Capture FSM, position counters and bank arbitration
  // ---------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [XW-1:0]     x_q, x_d, xc;
  logic [YW-1:0]     y_q, y_d, yc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pending_q, pending_d;
  logic              rd_bank_q, rd_bank_d;
  logic              wr_bank_q, wr_bank_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [1:0]        wr_data_q, wr_data_d;
  logic              frame_ok_q, frame_ok_d;
  logic              frame_err_q;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              err;
  logic              start;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    pending_d  = pending_q;
    rd_bank_d  = rd_bank_q;
    wr_bank_d  = wr_bank_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    frame_ok_d = 1'b0;
    err        = 1'b0;
    start      = 1'b0;
    xc         = x_q;
    yc         = y_q;

    case (state_q)
      ST_CAPTURE: begin
        if (ev_vs_q) begin
          // A new frame started before this one finished: count it, restart.
          err   = 1'b1;
          start = 1'b1;
        end else begin
          // Line advance is resolved first so a coincident pixel lands at x=0.
          if (ev_hs_q) begin
            if (x_q == X_END) begin
              xc = '0;
              yc = y_q + YW'(1);
            end else if (x_q != '0) begin
              err = 1'b1;
            end
          end
          if (ev_iclk_q && !err) begin
            if (xc == X_END) begin
              err = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = {wr_bank_q, addr_q};
              wr_data_d = ev_data_q;
              addr_d    = addr_q + ADDR_W'(1);
              xc        = xc + XW'(1);
              if (xc == X_END && yc == Y_LAST) begin
                state_d    = ST_DONE;
                frame_ok_d = 1'b1;
                pending_d  = 1'b1;
              end
            end
          end
          x_d = xc;
          y_d = yc;
          if (err) state_d = ST_WAIT;
        end
      end
      ST_WAIT, ST_DONE: begin
        if (ev_vs_q) start = 1'b1;
      end
      default: state_d = ST_WAIT;
    endcase

    // A finished frame still waiting for its swap is simply overwritten.
    if (start) begin
      state_d   = ST_CAPTURE;
      x_d       = '0;
      y_d       = '0;
      addr_d    = '0;
      pending_d = 1'b0;
    end

    // Swap looks at the registered pending, so a frame finishing in the same
    // cycle as the ovsync rise waits for the following one.
    if (ovs_rise && pending_q) begin
      rd_bank_d = wr_bank_q;
      wr_bank_d = ~wr_bank_q;
      pending_d = 1'b0;
    end

    err_cnt_d = err_cnt_q;
    if (err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      pending_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_bank_q   <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 2'd0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      pending_q   <= pending_d;
      rd_bank_q   <= rd_bank_d;
      wr_bank_q   <= wr_bank_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= err;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_bank   = rd_bank_q;
  assign bus.capturing = (state_q == ST_CAPTURE);
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_count = err_cnt_q;

  assign dbg_state_o   = state_q;
  assign dbg_pending_o = pending_q;
  assign dbg_wr_bank_o = wr_bank_q;

endmodule

// File: tb/tb_gb_capture_ctrl.sv
// Directed bench for gb_capture_ctrl: one full-size instance for a complete
// 160x144 frame, one 4x3 instance for bank, error and timing corner cases.
module tb_gb_capture_ctrl;

  localparam int F_AW = 15;
  localparam int S_H  = 4;
  localparam int S_V  = 3;
  localparam int S_AW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gb_capture_ctrl_if #(.ADDR_W(F_AW)) f_if ();
  gb_capture_ctrl_if #(.ADDR_W(S_AW)) s_if ();

  logic [1:0] f_state, s_state;
  logic       f_pend, s_pend, f_wb, s_wb;

  gb_capture_ctrl #(.H_PIX(160), .V_LINES(144), .ADDR_W(F_AW), .SYNC_STAGES(2)) u_full (
    .clk(clk), .rst_n(rst_n), .bus(f_if),
    .dbg_state_o(f_state), .dbg_pending_o(f_pend), .dbg_wr_bank_o(f_wb)
  );

  gb_capture_ctrl #(.H_PIX(S_H), .V_LINES(S_V), .ADDR_W(S_AW), .SYNC_STAGES(2)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(s_if),
    .dbg_state_o(s_state), .dbg_pending_o(s_pend), .dbg_wr_bank_o(s_wb)
  );

  // ---------------- scoreboard ----------------
  logic [17:0] exp_f[$];
  logic [6:0]  exp_s[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [17:0] ef;
    logic [6:0]  es;
    if (f_if.wr_en === 1'b1) begin
      if (exp_f.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL full_unexpected_write: observed addr %0h expected no write", f_if.wr_addr);
      end else begin
        ef = exp_f.pop_front();
        chk("full_wr", {14'b0, f_if.wr_data, f_if.wr_addr}, {14'b0, ef});
      end
    end
    if (s_if.wr_en === 1'b1) begin
      if (exp_s.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL small_unexpected_write: observed addr %0h expected no write", s_if.wr_addr);
      end else begin
        es = exp_s.pop_front();
        chk("small_wr", {25'b0, s_if.wr_data, s_if.wr_addr}, {25'b0, es});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pins(input bit sel, input logic c, input logic h, input logic v,
                          input logic [1:0] d);
    if (sel) begin
      s_if.iclk = c; s_if.ihsync = h; s_if.ivsync = v; s_if.idata = d;
    end else begin
      f_if.iclk = c; f_if.ihsync = h; f_if.ivsync = v; f_if.idata = d;
    end
  endtask

  task automatic set_ovs(input bit sel, input logic v);
    if (sel) s_if.ovsync = v;
    else     f_if.ovsync = v;
  endtask

  function automatic logic [31:0] exp_word(input bit sel, input logic bank, input int idx,
                                           input logic [1:0] d);
    logic [14:0] i15;
    i15 = 15'(idx);
    if (sel) return {25'b0, d, bank, i15[3:0]};
    return {14'b0, d, bank, i15};
  endfunction

  task automatic push_exp(input bit sel, input logic [31:0] e);
    if (sel) exp_s.push_back(e[6:0]);
    else     exp_f.push_back(e[17:0]);
  endtask

  task automatic pix(input bit sel, input logic [1:0] d, input logic [31:0] e, input bit wr);
    set_pins(sel, 1'b1, 1'b0, 1'b0, d);
    if (wr) push_exp(sel, e);
    tick(1);
    set_pins(sel, 1'b0, 1'b0, 1'b0, d);
    tick(1);
  endtask

  task automatic hs(input bit sel);
    set_pins(sel, 1'b0, 1'b1, 1'b0, 2'd0);
    tick(1);
    set_pins(sel, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(1);
  endtask

  task automatic vs(input bit sel);
    set_pins(sel, 1'b0, 1'b0, 1'b1, 2'd0);
    tick(1);
    set_pins(sel, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(1);
  endtask

  task automatic send_frame(input bit sel, input logic bank, input int h, input int v,
                            input bit omit_last);
    for (int y = 0; y < v; y++) begin
      for (int x = 0; x < h; x++) begin
        if (!(omit_last && y == v - 1 && x == h - 1))
          pix(sel, 2'(x + y), exp_word(sel, bank, y * h + x, 2'(x + y)), 1'b1);
      end
      if (y < v - 1) hs(sel);
    end
  endtask

  // which: 0 full frame_ok, 1 small frame_ok, 2 small frame_err
  task automatic wait_pulse(input string tag, input int which);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = (f_if.frame_ok === 1'b1);
        1:       seen = (s_if.frame_ok === 1'b1);
        default: seen = (s_if.frame_err === 1'b1);
      endcase
    end
    chk(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic check_reset(input bit sel, input string p);
    if (sel) begin
      chk({p, "_wr_en"},     {31'b0, s_if.wr_en},     32'd0);
      chk({p, "_wr_addr"},   {27'b0, s_if.wr_addr},   32'd0);
      chk({p, "_wr_data"},   {30'b0, s_if.wr_data},   32'd0);
      chk({p, "_rd_bank"},   {31'b0, s_if.rd_bank},   32'd0);
      chk({p, "_capturing"}, {31'b0, s_if.capturing}, 32'd0);
      chk({p, "_frame_ok"},  {31'b0, s_if.frame_ok},  32'd0);
      chk({p, "_frame_err"}, {31'b0, s_if.frame_err}, 32'd0);
      chk({p, "_err_count"}, {24'b0, s_if.err_count}, 32'd0);
      chk({p, "_state"},     {30'b0, s_state},        32'd0);
      chk({p, "_pending"},   {31'b0, s_pend},         32'd0);
      chk({p, "_wr_bank"},   {31'b0, s_wb},           32'd1);
    end else begin
      chk({p, "_wr_en"},     {31'b0, f_if.wr_en},     32'd0);
      chk({p, "_wr_addr"},   {16'b0, f_if.wr_addr},   32'd0);
      chk({p, "_rd_bank"},   {31'b0, f_if.rd_bank},   32'd0);
      chk({p, "_err_count"}, {24'b0, f_if.err_count}, 32'd0);
      chk({p, "_state"},     {30'b0, f_state},        32'd0);
      chk({p, "_wr_bank"},   {31'b0, f_wb},           32'd1);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    set_pins(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    set_pins(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    set_ovs(1'b0, 1'b0);
    set_ovs(1'b1, 1'b0);
    rst_n = 1'b0;
    tick(3);
    check_reset(1'b0, "rst_full");
    check_reset(1'b1, "rst_small");
    rst_n = 1'b1;
    tick(2);

    // Full 160x144 frame into bank 1
    vs(1'b0);
    send_frame(1'b0, 1'b1, 160, 144, 1'b0);
    wait_pulse("t1_frame_ok", 0);
    tick(2);
    chk("t1_pending",   {31'b0, f_pend},          32'd1);
    chk("t1_state",     {30'b0, f_state},         32'd2);
    chk("t1_capturing", {31'b0, f_if.capturing},  32'd0);
    chk("t1_last_addr", {16'b0, f_if.wr_addr},    32'hD9FF);
    chk("t1_err_count", {24'b0, f_if.err_count},  32'd0);
    chk("t1_queue",     exp_f.size(),             32'd0);

    // Swap on ovsync, then a second ovsync without a new frame
    set_ovs(1'b0, 1'b1);
    tick(1);
    chk("t2_rd_bank",   {31'b0, f_if.rd_bank}, 32'd1);
    chk("t2_wr_bank",   {31'b0, f_wb},         32'd0);
    chk("t2_pending",   {31'b0, f_pend},       32'd0);
    set_ovs(1'b0, 1'b0);
    tick(2);
    set_ovs(1'b0, 1'b1);
    tick(2);
    set_ovs(1'b0, 1'b0);
    chk("t2_rd_bank_hold", {31'b0, f_if.rd_bank}, 32'd1);
    chk("t2_wr_bank_hold", {31'b0, f_wb},         32'd0);
    vs(1'b0);
    pix(1'b0, 2'd3, exp_word(1'b0, 1'b0, 0, 2'd3), 1'b1);
    pix(1'b0, 2'd1, exp_word(1'b0, 1'b0, 1, 2'd1), 1'b1);
    tick(4);
    chk("t2_bank0_addr", {16'b0, f_if.wr_addr},   32'h0001);
    chk("t2_capturing",  {31'b0, f_if.capturing}, 32'd1);

    // Short line on the small instance
    vs(1'b1);
    for (int x = 0; x < 4; x++) pix(1'b1, 2'(x), exp_word(1'b1, 1'b1, x, 2'(x)), 1'b1);
    hs(1'b1);
    for (int x = 0; x < 3; x++) pix(1'b1, 2'(x), exp_word(1'b1, 1'b1, 4 + x, 2'(x)), 1'b1);
    hs(1'b1);
    wait_pulse("t3_frame_err", 2);
    chk("t3_err_count", {24'b0, s_if.err_count}, 32'd1);
    chk("t3_state",     {30'b0, s_state},        32'd0);
    for (int x = 0; x < 3; x++) pix(1'b1, 2'd2, 32'd0, 1'b0);
    hs(1'b1);
    tick(4);
    chk("t3_rd_bank",   {31'b0, s_if.rd_bank},   32'd0);

    // Fifth pixel on a 4-pixel line, then error counter saturation
    vs(1'b1);
    for (int x = 0; x < 4; x++) pix(1'b1, 2'd1, exp_word(1'b1, 1'b1, x, 2'd1), 1'b1);
    pix(1'b1, 2'd1, 32'd0, 1'b0);
    wait_pulse("t4_frame_err", 2);
    chk("t4_err_count", {24'b0, s_if.err_count}, 32'd2);
    repeat (301) vs(1'b1);
    tick(4);
    chk("t4_err_sat",   {24'b0, s_if.err_count}, 32'd255);
    chk("t4_state",     {30'b0, s_state},        32'd1);

    // Frame completes in the same cycle as the ovsync rise
    send_frame(1'b1, 1'b1, S_H, S_V, 1'b1);
    set_pins(1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    push_exp(1'b1, exp_word(1'b1, 1'b1, 11, 2'd1));
    tick(1);
    set_pins(1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    tick(2);
    set_ovs(1'b1, 1'b1);
    tick(1);
    chk("t5_frame_ok",     {31'b0, s_if.frame_ok}, 32'd1);
    chk("t5_pending",      {31'b0, s_pend},        32'd1);
    chk("t5_no_swap",      {31'b0, s_if.rd_bank},  32'd0);
    set_ovs(1'b1, 1'b0);
    tick(2);
    set_ovs(1'b1, 1'b1);
    tick(1);
    chk("t5_swap_rd",      {31'b0, s_if.rd_bank},  32'd1);
    chk("t5_swap_wr",      {31'b0, s_wb},          32'd0);
    chk("t5_swap_pending", {31'b0, s_pend},        32'd0);
    set_ovs(1'b1, 1'b0);
    tick(2);
    vs(1'b1);
    send_frame(1'b1, 1'b0, S_H, S_V, 1'b0);
    wait_pulse("t5_frame2_ok", 1);
    chk("t5_pending2",     {31'b0, s_pend},        32'd1);
    vs(1'b1);
    tick(3);
    chk("t5_drop_pending", {31'b0, s_pend},        32'd0);
    chk("t5_drop_state",   {30'b0, s_state},       32'd1);
    set_ovs(1'b1, 1'b1);
    tick(2);
    set_ovs(1'b1, 1'b0);
    tick(1);
    chk("t5_drop_rd",      {31'b0, s_if.rd_bank},  32'd1);
    chk("t5_drop_wr",      {31'b0, s_wb},          32'd0);

    // Write latency: iclk sampled before E0, wr_en visible after E3
    set_pins(1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
    push_exp(1'b1, exp_word(1'b1, 1'b0, 0, 2'd2));
    tick(1);
    chk("t6_lat1", {31'b0, s_if.wr_en}, 32'd0);
    set_pins(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    tick(1);
    chk("t6_lat2", {31'b0, s_if.wr_en}, 32'd0);
    tick(1);
    chk("t6_lat3", {31'b0, s_if.wr_en}, 32'd0);
    tick(1);
    chk("t6_lat4_en",   {31'b0, s_if.wr_en},   32'd1);
    chk("t6_lat4_data", {30'b0, s_if.wr_data}, 32'd2);
    chk("t6_lat4_addr", {27'b0, s_if.wr_addr}, 32'd0);
    for (int x = 1; x < 4; x++) pix(1'b1, 2'd3, exp_word(1'b1, 1'b0, x, 2'd3), 1'b1);
    set_pins(1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
    push_exp(1'b1, exp_word(1'b1, 1'b0, 4, 2'd1));
    tick(1);
    set_pins(1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    tick(4);
    chk("t6_hs_iclk_addr", {27'b0, s_if.wr_addr},   32'h04);
    chk("t6_capturing",    {31'b0, s_if.capturing}, 32'd1);

    // Reset while a write strobe is high
    set_pins(1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
    push_exp(1'b1, exp_word(1'b1, 1'b0, 5, 2'd3));
    tick(1);
    set_pins(1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
    tick(3);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset(1'b1, "t6_rst");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    vs(1'b1);
    pix(1'b1, 2'd1, exp_word(1'b1, 1'b1, 0, 2'd1), 1'b1);
    tick(6);
    chk("t6_restart_addr", {27'b0, s_if.wr_addr}, 32'h10);

    chk("end_queue_full",  exp_f.size(), 32'd0);
    chk("end_queue_small", exp_s.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
